// File: rtl/trdb_pkg.sv
// Shared types for the trace debugger blocks.
package trdb_pkg;

  typedef enum logic [1:0] {
    DELTA_ADDRESS = 2'b00,
    FULL_ADDRESS  = 2'b01,
    DIFF_ADDRESS  = 2'b10,
    SIGN_ADDRESS  = 2'b11
  } ioptions_e;

endpackage

// File: rtl/pulp_clock_gating.sv
// Latch-based glitch-free clock gate: enable is captured while the clock is low.
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_clk_en;

  always_latch begin
    if (!clk_i) r_clk_en <= en_i | test_en_i;
  end

  assign clk_o = clk_i & r_clk_en;

endmodule

// File: rtl/trdb_ctrl_regs.sv
// Trace encoder control/configuration registers: APB-lite slave plus one
// OFF/ON/DRAIN gating state machine per trace channel.
module trdb_ctrl_regs
  import trdb_pkg::*;
#(
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic [NUM_CH-1:0] trace_req_on_i,
  input  logic [NUM_CH-1:0] trace_req_off_i,
  input  logic              encapsulator_ready_i,
  output logic [NUM_CH-1:0] trace_enable_o,
  output logic              trace_activated_o,
  output logic              nocontext_o,
  output logic              notime_o,
  output logic              delta_address_o,
  output logic              full_address_o,
  output logic              encoder_mode_o,
  output ioptions_e         configuration_o,
  output logic              clk_gated_o
);

  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_DRAIN} ch_state_e;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  logic              w_access, w_mapped, w_wr;
  logic              w_ctrl_wr, w_cmd_wr, w_stall_wr;
  logic [1:0]        w_word;
  logic [4:0]        r_ctrl;
  logic [31:0]       r_stall;
  logic [31:0]       w_status;
  logic [NUM_CH-1:0] r_prev_on, r_prev_off;
  logic [NUM_CH-1:0] w_sw_on, w_sw_off, w_start, w_stop;
  ch_state_e         r_state     [NUM_CH];
  ch_state_e         w_state_nxt [NUM_CH];
  logic [7:0]        r_cnt       [NUM_CH];
  logic [7:0]        w_cnt_nxt   [NUM_CH];
  logic              w_unused;

  assign w_access   = psel_i & penable_i;
  assign w_word     = paddr_i[3:2];
  assign w_mapped   = (paddr_i[ADDR_W-1:4] == '0);
  assign w_wr       = w_access & pwrite_i & w_mapped;
  assign w_ctrl_wr  = w_wr & (w_word == 2'd0);
  assign w_cmd_wr   = w_wr & (w_word == 2'd1);
  assign w_stall_wr = w_wr & (w_word == 2'd3);

  assign w_sw_on  = w_cmd_wr ? pwdata_i[NUM_CH-1:0]  : '0;
  assign w_sw_off = w_cmd_wr ? pwdata_i[16 +: NUM_CH] : '0;
  assign w_start  = (trace_req_on_i  & ~r_prev_on)  | w_sw_on;
  assign w_stop   = (trace_req_off_i & ~r_prev_off) | w_sw_off;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev_on  <= '0;
      r_prev_off <= '0;
      r_ctrl     <= 5'h0F;
    end else begin
      r_prev_on  <= trace_req_on_i;
      r_prev_off <= trace_req_off_i;
      if (w_ctrl_wr) r_ctrl <= pwdata_i[4:0];
    end
  end

  // Stall counter: a software write takes priority over counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
    end else if (w_stall_wr) begin
      r_stall <= '0;
    end else if ((|trace_enable_o) && !encapsulator_ready_i && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_OFF;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Stop requests dominate starts; requests arriving during DRAIN are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      unique case (r_state[i])
        ST_OFF: begin
          if (r_ctrl[0] && encapsulator_ready_i && w_start[i] && !w_stop[i])
            w_state_nxt[i] = ST_ON;
        end
        ST_ON: begin
          if (w_stop[i] || !r_ctrl[0]) begin
            w_state_nxt[i] = ST_DRAIN;
            w_cnt_nxt[i]   = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_cnt[i] == '0) w_state_nxt[i] = ST_OFF;
          else                w_cnt_nxt[i]   = r_cnt[i] - 8'd1;
        end
        default: w_state_nxt[i] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    w_status       = '0;
    trace_enable_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      trace_enable_o[i] = (r_state[i] == ST_ON);
      w_status[i]       = (r_state[i] == ST_ON);
      w_status[16 + i]  = (r_state[i] == ST_DRAIN);
    end
  end

  always_comb begin
    prdata_o = '0;
    if (w_access && w_mapped) begin
      case (w_word)
        2'd0:    prdata_o = {27'd0, r_ctrl};
        2'd2:    prdata_o = w_status;
        2'd3:    prdata_o = r_stall;
        default: prdata_o = '0;
      endcase
    end
  end

  assign pready_o  = 1'b1;
  assign pslverr_o = w_access & (~w_mapped | (pwrite_i & (w_word == 2'd2)));

  assign trace_activated_o = r_ctrl[0];
  assign nocontext_o       = r_ctrl[1];
  assign notime_o          = r_ctrl[2];
  assign delta_address_o   = r_ctrl[3];
  assign full_address_o    = r_ctrl[4];
  assign encoder_mode_o    = 1'b0;
  assign configuration_o   = r_ctrl[4] ? FULL_ADDRESS : DELTA_ADDRESS;

  pulp_clock_gating u_clk_gate (
    .clk_i     (clk_i),
    .en_i      (r_ctrl[0]),
    .test_en_i (1'b0),
    .clk_o     (clk_gated_o)
  );

  // Byte-lane bits of the address and unused write-data bits.
  assign w_unused = ^{paddr_i[1:0], pwdata_i};

endmodule

// File: tb/tb_trdb_ctrl_regs.sv
// Scoreboard bench for trdb_ctrl_regs: behavioural channel model, directed
// scenarios followed by randomized triggers, back-pressure and APB traffic.
module tb_trdb_ctrl_regs;

  localparam int NCH = 2;
  localparam int DRN = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]     paddr = '0;
  logic [31:0]    pwdata = '0;
  logic [31:0]    prdata;
  logic           pready, pslverr;
  logic [NCH-1:0] on_i = '0, off_i = '0;
  logic           ready = 1'b1;
  logic [NCH-1:0] en;
  logic           act, noctx, notime, dlt, full, encm, clkg;
  trdb_pkg::ioptions_e cfg;

  always #5 clk = ~clk;

  trdb_ctrl_regs #(.NUM_CH(NCH), .ADDR_W(8), .DRAIN_CYCLES(DRN)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .psel_i               (psel),
    .penable_i            (penable),
    .pwrite_i             (pwrite),
    .paddr_i              (paddr),
    .pwdata_i             (pwdata),
    .prdata_o             (prdata),
    .pready_o             (pready),
    .pslverr_o            (pslverr),
    .trace_req_on_i       (on_i),
    .trace_req_off_i      (off_i),
    .encapsulator_ready_i (ready),
    .trace_enable_o       (en),
    .trace_activated_o    (act),
    .nocontext_o          (noctx),
    .notime_o             (notime),
    .delta_address_o      (dlt),
    .full_address_o       (full),
    .encoder_mode_o       (encm),
    .configuration_o      (cfg),
    .clk_gated_o          (clkg)
  );

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    logic [7:0]  addr;
  } sb_t;
  sb_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Reference model: channel is ON, draining (left > 0 cycles remain) or OFF.
  bit             m_on   [NCH];
  int             m_left [NCH];
  logic [4:0]     m_ctrl;
  logic [31:0]    m_stall;
  logic [NCH-1:0] m_pon, m_poff;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) begin
      m_on[c]   = 1'b0;
      m_left[c] = 0;
    end
    m_ctrl  = 5'h0F;
    m_stall = '0;
    m_pon   = '0;
    m_poff  = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] rise_on, rise_off, sw_on, sw_off;
    bit wr, any_on, start, stop;
    int word;
    wr      = psel && penable && pwrite && (paddr < 8'h10);
    word    = int'(paddr[7:2]);
    rise_on  = on_i  & ~m_pon;
    rise_off = off_i & ~m_poff;
    sw_on  = (wr && word == 1) ? pwdata[NCH-1:0]  : '0;
    sw_off = (wr && word == 1) ? pwdata[16 +: NCH] : '0;
    any_on = 1'b0;
    for (int c = 0; c < NCH; c++) any_on |= m_on[c];
    if (any_on && !ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    for (int c = 0; c < NCH; c++) begin
      start = rise_on[c] | sw_on[c];
      stop  = rise_off[c] | sw_off[c];
      if (m_on[c]) begin
        if (stop || !m_ctrl[0]) begin
          m_on[c]   = 1'b0;
          m_left[c] = DRN;
        end
      end else if (m_left[c] > 0) begin
        m_left[c] = m_left[c] - 1;
      end else if (m_ctrl[0] && ready && start && !stop) begin
        m_on[c] = 1'b1;
      end
    end
    if (wr && word == 0) m_ctrl = pwdata[4:0];
    if (wr && word == 3) m_stall = '0;
    m_pon  = on_i;
    m_poff = off_i;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] s;
    s = '0;
    if (a >= 8'h10) return '0;
    case (a[3:2])
      2'd0: return {27'd0, m_ctrl};
      2'd2: begin
        for (int c = 0; c < NCH; c++) begin
          s[c]      = m_on[c];
          s[16 + c] = (m_left[c] > 0);
        end
        return s;
      end
      2'd3: return m_stall;
      default: return '0;
    endcase
  endfunction

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else        model_step();
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin
    logic [NCH-1:0] exp_en;
    sb_t it;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) exp_en[c] = m_on[c];
      chk("trace_enable", 32'(en), 32'(exp_en));
      chk("trace_activated", 32'(act), 32'(m_ctrl[0]));
      chk("nocontext", 32'(noctx), 32'(m_ctrl[1]));
      chk("notime", 32'(notime), 32'(m_ctrl[2]));
      chk("delta_address", 32'(dlt), 32'(m_ctrl[3]));
      chk("full_address", 32'(full), 32'(m_ctrl[4]));
      chk("configuration", 32'(cfg),
          m_ctrl[4] ? 32'(trdb_pkg::FULL_ADDRESS) : 32'(trdb_pkg::DELTA_ADDRESS));
      chk("encoder_mode", 32'(encm), 32'd0);
      chk("pready", 32'(pready), 32'd1);
      if (psel && penable) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: access phase with no expectation queued at %0t", $time);
        end else begin
          it = sbq.pop_front();
          chk($sformatf("pslverr@%02h", it.addr), 32'(pslverr), 32'(it.err));
          if (it.rd) chk($sformatf("prdata@%02h", it.addr), prdata, it.data);
        end
      end else begin
        chk("prdata_idle", prdata, 32'd0);
        chk("pslverr_idle", 32'(pslverr), 32'd0);
      end
    end
  end

  // Gated clock follows ACTIVE as it stood during the preceding low phase.
  initial begin
    logic g;
    forever begin
      @(negedge clk);
      #4 g = m_ctrl[0];
      @(posedge clk);
      #2 chk("clk_gated", 32'(clkg), 32'(g));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d);
    sb_t it;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable  = 1'b1;
    it.rd    = !wr;
    it.addr  = a;
    it.data  = model_read(a);
    it.err   = (a >= 8'h10) || (wr && a[3:2] == 2'd2);
    sbq.push_back(it);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse_on(input logic [NCH-1:0] v);
    on_i = v; tick(); on_i = '0;
  endtask

  task automatic pulse_off(input logic [NCH-1:0] v);
    off_i = v; tick(); off_i = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    #1 rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    apb(1'b0, 8'h00, '0);
    apb(1'b0, 8'h08, '0);
    apb(1'b0, 8'h0C, '0);

    // Trigger start and stop on channel 1, watching DRAIN in STATUS.
    pulse_on(2'b10);
    ticks(4);
    pulse_off(2'b10);
    apb(1'b0, 8'h08, '0);
    apb(1'b0, 8'h08, '0);
    ticks(3);
    apb(1'b0, 8'h08, '0);

    // Back-pressure while ON only counts stalls.
    pulse_on(2'b01);
    ready = 1'b0;
    ticks(7);
    ready = 1'b1;
    apb(1'b0, 8'h0C, '0);
    apb(1'b1, 8'h0C, 32'h1234_5678);
    apb(1'b0, 8'h0C, '0);
    apb(1'b1, 8'h04, 32'h0001_0000);
    ticks(6);

    // Software commands and simultaneous on/off.
    apb(1'b1, 8'h04, 32'h0000_0001);
    ticks(2);
    apb(1'b1, 8'h04, 32'h0001_0000);
    ticks(6);
    apb(1'b1, 8'h04, 32'h0002_0002);
    on_i = 2'b11; off_i = 2'b11;
    tick();
    on_i = '0; off_i = '0;
    ticks(2);

    // Clearing ACTIVE drains ON channels and blocks new starts.
    apb(1'b1, 8'h04, 32'h0000_0001);
    apb(1'b1, 8'h00, 32'h0000_001E);
    ticks(2);
    pulse_on(2'b11);
    apb(1'b1, 8'h04, 32'h0000_0003);
    ticks(5);
    apb(1'b0, 8'h08, '0);
    apb(1'b1, 8'h00, 32'h0000_000F);

    // Error responses leave registers untouched.
    apb(1'b0, 8'h10, '0);
    apb(1'b1, 8'h08, 32'hFFFF_FFFF);
    apb(1'b1, 8'h14, 32'h0000_0000);
    apb(1'b0, 8'h08, '0);
    apb(1'b0, 8'h00, '0);

    // Reset in DRAIN; a level held high through reset release acts as a rise.
    pulse_on(2'b10);
    ticks(2);
    pulse_off(2'b10);
    tick();
    on_i  = 2'b10;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    on_i = '0;
    apb(1'b0, 8'h08, '0);
    ticks(2);

    for (int n = 0; n < 400; n++) begin
      on_i  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      off_i = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
      ready = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        a = {2'b00, 4'($urandom_range(0, 5)), 2'($urandom)};
        d = $urandom;
        if (a[5:2] == 4'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        apb(1'($urandom), a, d);
      end else begin
        tick();
      end
    end
    on_i = '0; off_i = '0; ready = 1'b1;
    ticks(3);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trdb_ctrl_regs.md
# trdb_ctrl_regs

Parametrised, software-programmable control and configuration register block for the trace encoder. It supports `NUM_CH` independently gated trace channels and an APB-lite slave port. Each channel runs its own OFF/ON/DRAIN state machine, driven by trigger edges, software commands and encapsulator back-pressure. The block sits between the trigger unit/filter, the system bus and the packet emitter, and feeds enable and option signals to the rest of `trdb`.

## Interface
Parameters:
- `NUM_CH`, 1, number of trace channels (1..16)
- `ADDR_W`, 8, APB address width
- `DRAIN_CYCLES`, 4, cycles a channel stays in DRAIN before OFF (1..255)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `psel_i`, `penable_i`, `pwrite_i`  in  1  APB control
- `paddr_i`  in  ADDR_W  byte address; bits [1:0] ignored
- `pwdata_i`  in  32  write data
- `prdata_o`  out  32  read data
- `pready_o`  out  1  tied 1
- `pslverr_o`  out  1  error response
- `trace_req_on_i`  in  NUM_CH  per-channel start trigger (level; rising edge used)
- `trace_req_off_i`  in  NUM_CH  per-channel stop request from filter (rising edge used)
- `encapsulator_ready_i`  in  1  downstream ready
- `trace_enable_o`  out  NUM_CH  channel in ON state
- `trace_activated_o`  out  1  CTRL.ACTIVE
- `nocontext_o`, `notime_o`, `delta_address_o`, `full_address_o`  out  1  CTRL option bits
- `encoder_mode_o`  out  1  constant 0
- `configuration_o`  out  ioptions_e  `FULL_ADDRESS` if CTRL.FULL_ADDR, else `DELTA_ADDRESS`
- `clk_gated_o`  out  1  `clk_i` gated by `pulp_clock_gating`; en = CTRL.ACTIVE, test_en = 0

## Operation
- Register map (offset, access):
  - 0x00 CTRL, RW: bit0 ACTIVE, bit1 NOCONTEXT, bit2 NOTIME, bit3 DELTA_ADDR, bit4 FULL_ADDR; other bits read 0; reset 0x0000000F.
  - 0x04 CMD, WO: bits[NUM_CH-1:0] are SW-on pulses; bits[16+NUM_CH-1:16] are SW-off pulses; reads 0.
  - 0x08 STATUS, RO: [NUM_CH-1:0] ON; [16+NUM_CH-1:16] DRAIN.
  - 0x0C STALL_CNT, RW: cycles with any channel ON and `encapsulator_ready_i`=0; saturates at 0xFFFFFFFF; any write clears it to 0.
- APB: access phase is `psel_i & penable_i`. Writes commit at the clock edge ending the access phase. `prdata_o` is combinational during the access phase and 0 otherwise. `pslverr_o`=1 in the access phase for an unmapped offset or a write to STATUS; such writes have no effect.
- Edge detect per trigger bit on `clk_i`: `prev` register resets to 0; rise = in & ~prev.
- Per-channel FSM, with states OFF, ON and DRAIN:
  - OFF→ON: ACTIVE & `encapsulator_ready_i` & (rise_on | sw_on) & ~(rise_off | sw_off).
  - ON→DRAIN: rise_off | sw_off | ~ACTIVE. `encapsulator_ready_i` low does NOT leave ON; it only counts stall cycles.
  - DRAIN→OFF: after DRAIN_CYCLES cycles. An 8-bit down-counter loads DRAIN_CYCLES-1 on entry. On-requests during DRAIN are dropped.
- `trace_enable_o[i]` = (state==ON), registered.
- ACTIVE cleared forces every ON channel to DRAIN on the next edge. OFF channels cannot start while ACTIVE=0.

## Timing
- All state registers reset to: FSM OFF, counters 0, CTRL 0x0F, `prev` 0.
- Output values during reset: `trace_enable_o`=0, `trace_activated_o`=1, `nocontext_o`=`notime_o`=`delta_address_o`=1, `full_address_o`=0, `pslverr_o`=0, `prdata_o`=0.
- Trigger latency: trigger first high in cycle N gives `trace_enable_o` high from cycle N+1.
- SW latency: CMD write access phase in cycle N gives the state change visible in cycle N+1. CTRL writes change the option outputs in cycle N+1.
- DRAIN lasts exactly DRAIN_CYCLES cycles. The channel reports OFF in STATUS on cycle DRAIN_CYCLES+1 after the stop edge.
- Simultaneous on and off requests: off wins in all states.
- A trigger level already high when reset is released counts as a rise in the first cycle.
- Mid-operation reset: all channels drop to OFF asynchronously and the stall counter clears.

## Test plan
- Reset, then read 0x00/0x08/0x0C → 0x0000000F / 0 / 0; all `trace_enable_o`=0; `configuration_o`=`DELTA_ADDRESS`.
- NUM_CH=2, ready=1, pulse `trace_req_on_i[1]` in cycle 5 → `trace_enable_o`=2'b10 from cycle 6. Then `trace_req_off_i[1]` in cycle 10 → enable low from 11, STATUS DRAIN bit 17 set for 4 cycles, then 0.
- Channel ON, `encapsulator_ready_i` low for 7 cycles → channel stays ON, STALL_CNT reads 7. Write 0x0C → reads 0.
- Write CMD=0x00000001, then CMD=0x00010000 → ch0 ON one cycle after the first write, DRAIN one cycle after the second. Same-cycle on+off triggers while OFF → stays OFF.
- Clear CTRL.ACTIVE with ch0 ON → DRAIN next cycle, `clk_gated_o` stops toggling. Triggers while ACTIVE=0 → no start.
- Read 0x10, or write 0x08 → `pslverr_o`=1, no register changes. Assert `rst_ni` low during DRAIN → OFF immediately, counter restarts after release.
